// File: rtl/pla_sweep_pkg.sv
// pla_sweep_pkg: shared state encoding, CRC constants and Gray helper for the PLA sweep reader.
`default_nettype none

package pla_sweep_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [15:0] CRC16_POLY = 16'h1021;
  localparam logic [15:0] SIG_INIT   = 16'hFFFF;

  function automatic logic [31:0] gray_of(input logic [31:0] i);
    return i ^ (i >> 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/pla_sweep_misr.sv
// pla_sweep_misr: serial CRC signature register; init loads all-ones, en shifts in one bit.
`default_nettype none

module pla_sweep_misr
  import pla_sweep_pkg::*;
#(
  parameter int               SIG_W = 16,
  parameter logic [SIG_W-1:0] POLY  = SIG_W'(CRC16_POLY)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_init,
  input  logic             i_en,
  input  logic             i_bit,
  output logic [SIG_W-1:0] o_sig
);

  logic [SIG_W-1:0] r_sig;
  logic [SIG_W-1:0] w_next;

  // Galois-style update: feedback is the outgoing MSB xored with the new bit.
  always_comb begin
    w_next = {r_sig[SIG_W-2:0], 1'b0} ^ ((r_sig[SIG_W-1] ^ i_bit) ? POLY : '0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sig <= '1;
    end else if (i_init) begin
      r_sig <= '1;
    end else if (i_en) begin
      r_sig <= w_next;
    end
  end

  assign o_sig = r_sig;

endmodule

`default_nettype wire

// File: rtl/pla_sweep_reader.sv
// pla_sweep_reader: sweeps all 2^N_IN vectors into a combinational PLA, capturing truth table,
// ON-set count and CRC signature. Optional Gray-code sweep order via macro PLA_SWEEP_GRAY_EN.
`default_nettype none

module pla_sweep_reader
  import pla_sweep_pkg::*;
#(
  parameter int N_IN   = 8,
  parameter int SETTLE = 1,
  parameter int SIG_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [N_IN-1:0]  x_out,
  input  logic             y_in,
  output logic [N_IN:0]    onset_count,
  output logic [SIG_W-1:0] signature,
  input  logic [N_IN-1:0]  tt_rd_addr,
  output logic             tt_rd_data
);

  localparam int              c_depth  = 1 << N_IN;
  localparam logic [N_IN-1:0] c_last   = '1;
  localparam logic [3:0]      c_settle = 4'(SETTLE);

  state_t             r_state;
  state_t             w_next_state;
  logic [N_IN-1:0]    r_idx;
  logic [3:0]         r_cnt;
  logic [N_IN:0]      r_onset;
  logic [c_depth-1:0] r_tt;
  logic               r_rd_data;
  logic [N_IN-1:0]    w_x;
  logic               w_accept;
  logic               w_sample;
  logic               w_last;

`ifdef PLA_SWEEP_GRAY_EN
  assign w_x = N_IN'(gray_of(32'(r_idx)));
`else
  assign w_x = r_idx;
`endif

  assign w_accept = start && (r_state != DRIVE);
  assign w_sample = (r_state == DRIVE) && (r_cnt == 4'd0);
  assign w_last   = w_sample && (r_idx == c_last);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (start)  w_next_state = DRIVE;
      DRIVE:   if (w_last) w_next_state = DONE;
      DONE:    if (start)  w_next_state = DRIVE;
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (r_state)
      DRIVE:   busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // The index is not advanced past the terminal vector so x_out holds it in DONE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_idx   <= '0;
      r_cnt   <= 4'd0;
      r_onset <= '0;
      r_tt    <= '0;
    end else if (w_accept) begin
      r_idx   <= '0;
      r_cnt   <= c_settle;
      r_onset <= '0;
    end else if (r_state == DRIVE) begin
      if (r_cnt != 4'd0) begin
        r_cnt <= r_cnt - 4'd1;
      end else begin
        r_tt[w_x] <= y_in;
        r_onset   <= r_onset + (N_IN + 1)'(y_in);
        if (!w_last) begin
          r_idx <= r_idx + N_IN'(1);
          r_cnt <= c_settle;
        end
      end
    end
  end

  // Write-first: a sample landing on the read address this cycle is forwarded.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rd_data <= 1'b0;
    end else if (w_sample && (tt_rd_addr == w_x)) begin
      r_rd_data <= y_in;
    end else begin
      r_rd_data <= r_tt[tt_rd_addr];
    end
  end

  pla_sweep_misr #(
    .SIG_W (SIG_W),
    .POLY  (SIG_W'(CRC16_POLY))
  ) u_misr (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_init (w_accept),
    .i_en   (w_sample),
    .i_bit  (y_in),
    .o_sig  (signature)
  );

  assign x_out       = w_x;
  assign onset_count = r_onset;
  assign tt_rd_data  = r_rd_data;

endmodule

`default_nettype wire
